// File: rtl/elevator_scheduler.sv
// Four-floor elevator controller: latches floor calls and serves them in SCAN order,
// with a fixed travel time per floor and an extendable door-open interval.
module elevator_scheduler #(
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [1:0] floor,
  output logic       dir_up,
  output logic       moving,
  output logic       door_open,
  output logic       arrive,
  output logic [3:0] pending
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } state_t;

  localparam logic [7:0] TRAVEL_LAST = 8'(TRAVEL_CYCLES - 1);
  localparam logic [7:0] DOOR_LAST   = 8'(DOOR_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [1:0] floor_reg, floor_next;
  logic [1:0] step_floor, door_floor;
  logic       dir_reg, dir_next;
  logic       arrive_reg, arrive_next;
  logic       door_enter;
  logic [3:0] pend_reg, pend_next;
  logic [3:0] req_mask;
  logic [3:0] above_mask, below_mask, here_mask;
  logic       any_above, any_below, any_here;

  // Per-floor position masks relative to the cabin.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_floor_mask
      localparam logic [1:0] FL = 2'(gi);
      assign above_mask[gi] = (floor_reg < FL);
      assign below_mask[gi] = (floor_reg > FL);
      assign here_mask[gi]  = (floor_reg == FL);
    end
  endgenerate

  assign any_above  = |(pend_reg & above_mask);
  assign any_below  = |(pend_reg & below_mask);
  assign any_here   = |(pend_reg & here_mask);
  assign step_floor = (state_reg == MOVE_UP) ? floor_reg + 2'd1 : floor_reg - 2'd1;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    floor_next  = floor_reg;
    dir_next    = dir_reg;
    arrive_next = 1'b0;
    door_enter  = 1'b0;
    door_floor  = floor_reg;
    req_mask    = 4'b0000;

    case (state_reg)
      IDLE: begin
        if (any_here) begin
          state_next = DOOR;
          cnt_next   = 8'd0;
          door_enter = 1'b1;
        end else if (any_above && (dir_reg || !any_below)) begin
          state_next = MOVE_UP;
          dir_next   = 1'b1;
          cnt_next   = 8'd0;
        end else if (any_below) begin
          state_next = MOVE_DOWN;
          dir_next   = 1'b0;
          cnt_next   = 8'd0;
        end
      end

      MOVE_UP, MOVE_DOWN: begin
        if (cnt_reg == TRAVEL_LAST) begin
          floor_next  = step_floor;
          arrive_next = 1'b1;
          cnt_next    = 8'd0;
          // Stop only if the call was already latched by this arrival edge.
          if (pend_reg[step_floor]) begin
            state_next = DOOR;
            door_enter = 1'b1;
            door_floor = step_floor;
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      DOOR: begin
        // A call for this floor keeps the door open instead of queuing a new stop.
        req_mask = here_mask;
        if (|(req & here_mask)) begin
          cnt_next = 8'd0;
        end else if (cnt_reg == DOOR_LAST) begin
          state_next = IDLE;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      default: state_next = IDLE;
    endcase

    pend_next = pend_reg | (req & ~req_mask);
    if (door_enter) begin
      pend_next[door_floor] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= 8'd0;
      floor_reg  <= 2'd0;
      dir_reg    <= 1'b1;
      arrive_reg <= 1'b0;
      pend_reg   <= 4'b0000;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      floor_reg  <= floor_next;
      dir_reg    <= dir_next;
      arrive_reg <= arrive_next;
      pend_reg   <= pend_next;
    end
  end

  assign floor     = floor_reg;
  assign dir_up    = dir_reg;
  assign moving    = (state_reg == MOVE_UP) || (state_reg == MOVE_DOWN);
  assign door_open = (state_reg == DOOR);
  assign arrive    = arrive_reg;
  assign pending   = pend_reg;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench: stimulus queues the expected sequence of output states with their
// durations in cycles; the monitor checks each output state when it changes.
module tb_elevator_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [1:0] floor;
  logic       dir_up, moving, door_open, arrive;
  logic [3:0] pending;

  always #5 clk = ~clk;

  elevator_scheduler #(
    .TRAVEL_CYCLES(4),
    .DOOR_CYCLES  (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .floor    (floor),
    .dir_up   (dir_up),
    .moving   (moving),
    .door_open(door_open),
    .arrive   (arrive),
    .pending  (pending)
  );

  // Output tuple: {floor[1:0], dir_up, moving, door_open, arrive, pending[3:0]}
  typedef struct {
    logic [9:0] out;
    int         len;  // 0 = any duration
    int         id;
  } exp_t;

  exp_t sb[$];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   next_id = 0;
  bit   done    = 1'b0;
  bit   flushed = 1'b0;

  function automatic logic [9:0] tup(input logic [1:0] f, input logic d, input logic mv,
                                     input logic dr, input logic ar, input logic [3:0] p);
    return {f, d, mv, dr, ar, p};
  endfunction

  task automatic expect_run(input logic [1:0] f, input logic d, input logic mv,
                            input logic dr, input logic ar, input logic [3:0] p, input int len);
    exp_t e;
    e.out = tup(f, d, mv, dr, ar, p);
    e.len = len;
    e.id  = next_id;
    next_id++;
    sb.push_back(e);
  endtask

  task automatic check_run(input logic [9:0] got, input int len);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_run: got out=%b len=%0d, required no further output change", got, len);
      return;
    end
    e = sb.pop_front();
    if (got !== e.out) begin
      n_bad++;
      $display("FAIL run%0d_out: got %b, required %b", e.id, got, e.out);
    end
    if (e.len != 0) begin
      n_cmp++;
      if (len != e.len) begin
        n_bad++;
        $display("FAIL run%0d_len: got %0d cycles, required %0d", e.id, len, e.len);
      end
    end
    $display("run %0d: out=%b len=%0d", e.id, got, len);
  endtask

  task automatic check_now(input string nm, input logic [9:0] want);
    logic [9:0] got;
    got = {floor, dir_up, moving, door_open, arrive, pending};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", nm, got, want);
    end else begin
      $display("check %s: out=%b", nm, got);
    end
  endtask

  // Monitor: measures how long each distinct output state persists.
  initial begin
    logic [9:0] prev, cur;
    int         run;
    bit         have;
    have = 1'b0;
    run  = 0;
    prev = '0;
    wait (rst === 1'b1);
    while (!flushed) begin
      @(negedge clk);
      cur = {floor, dir_up, moving, door_open, arrive, pending};
      if (done) begin
        if (have) check_run(prev, run);
        flushed = 1'b1;
      end else begin
        if (have && (cur !== prev)) begin
          check_run(prev, run);
          run = 0;
        end
        prev = cur;
        have = 1'b1;
        run++;
      end
    end
  end

  task automatic pulse_req(input logic [3:0] v);
    @(posedge clk);
    #1 req = v;
    @(posedge clk);
    #1 req = 4'b0000;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() <= 1) return;
      @(posedge clk);
    end
    n_cmp++;
    n_bad++;
    $display("FAIL drain_timeout: got %0d queued runs, required <= 1", sb.size());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, required finish within 100000 time units");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then call floor 2 from floor 0.
    expect_run(2'd0, 1, 0, 0, 0, 4'b0000, 0);
    #22 rst = 1'b1;
    expect_run(2'd0, 1, 0, 0, 0, 4'b0100, 1);
    expect_run(2'd0, 1, 1, 0, 0, 4'b0100, 4);
    expect_run(2'd1, 1, 1, 0, 1, 4'b0100, 1);
    expect_run(2'd1, 1, 1, 0, 0, 4'b0100, 3);
    expect_run(2'd2, 1, 0, 1, 1, 4'b0000, 1);
    expect_run(2'd2, 1, 0, 1, 0, 4'b0000, 2);
    expect_run(2'd2, 1, 0, 0, 0, 4'b0000, 0);
    pulse_req(4'b0100);
    drain();

    // Floor 2 heading up with calls at 3 and 0: serve 3, then sweep down to 0.
    expect_run(2'd2, 1, 0, 0, 0, 4'b1001, 1);
    expect_run(2'd2, 1, 1, 0, 0, 4'b1001, 4);
    expect_run(2'd3, 1, 0, 1, 1, 4'b0001, 1);
    expect_run(2'd3, 1, 0, 1, 0, 4'b0001, 2);
    expect_run(2'd3, 1, 0, 0, 0, 4'b0001, 1);
    expect_run(2'd3, 0, 1, 0, 0, 4'b0001, 4);
    expect_run(2'd2, 0, 1, 0, 1, 4'b0001, 1);
    expect_run(2'd2, 0, 1, 0, 0, 4'b0001, 3);
    expect_run(2'd1, 0, 1, 0, 1, 4'b0001, 1);
    expect_run(2'd1, 0, 1, 0, 0, 4'b0001, 3);
    expect_run(2'd0, 0, 0, 1, 1, 4'b0000, 1);
    expect_run(2'd0, 0, 0, 1, 0, 4'b0000, 2);
    expect_run(2'd0, 0, 0, 0, 0, 4'b0000, 0);
    pulse_req(4'b1001);
    drain();

    // Call for the current floor: door only, no travel.
    expect_run(2'd0, 0, 0, 0, 0, 4'b0001, 1);
    expect_run(2'd0, 0, 0, 1, 0, 4'b0000, 3);
    expect_run(2'd0, 0, 0, 0, 0, 4'b0000, 0);
    pulse_req(4'b0001);
    drain();

    // Heading to 3, floor 1 called before the arrival edge: stop at 1, then continue.
    expect_run(2'd0, 0, 0, 0, 0, 4'b1000, 1);
    expect_run(2'd0, 1, 1, 0, 0, 4'b1000, 2);
    expect_run(2'd0, 1, 1, 0, 0, 4'b1010, 2);
    expect_run(2'd1, 1, 0, 1, 1, 4'b1000, 1);
    expect_run(2'd1, 1, 0, 1, 0, 4'b1000, 2);
    expect_run(2'd1, 1, 0, 0, 0, 4'b1000, 1);
    expect_run(2'd1, 1, 1, 0, 0, 4'b1000, 4);
    expect_run(2'd2, 1, 1, 0, 1, 4'b1000, 1);
    expect_run(2'd2, 1, 1, 0, 0, 4'b1000, 3);
    expect_run(2'd3, 1, 0, 1, 1, 4'b0000, 1);
    expect_run(2'd3, 1, 0, 1, 0, 4'b0000, 2);
    expect_run(2'd3, 1, 0, 0, 0, 4'b0000, 0);
    pulse_req(4'b1000);
    repeat (2) @(posedge clk);
    #1 req = 4'b0010;
    @(posedge clk);
    #1 req = 4'b0000;
    drain();

    // Door at floor 2 re-requested on its last cycle: three more open cycles.
    expect_run(2'd3, 1, 0, 0, 0, 4'b0100, 1);
    expect_run(2'd3, 0, 1, 0, 0, 4'b0100, 4);
    expect_run(2'd2, 0, 0, 1, 1, 4'b0000, 1);
    expect_run(2'd2, 0, 0, 1, 0, 4'b0000, 5);
    expect_run(2'd2, 0, 0, 0, 0, 4'b0000, 0);
    pulse_req(4'b0100);
    repeat (7) @(posedge clk);
    #1 req = 4'b0100;
    @(posedge clk);
    #1 req = 4'b0000;
    drain();

    // Asynchronous reset in the middle of a downward trip.
    expect_run(2'd2, 0, 0, 0, 0, 4'b0001, 1);
    expect_run(2'd2, 0, 1, 0, 0, 4'b0001, 4);
    expect_run(2'd1, 0, 1, 0, 1, 4'b0001, 1);
    expect_run(2'd1, 0, 1, 0, 0, 4'b0001, 1);
    expect_run(2'd0, 1, 0, 0, 0, 4'b0000, 0);
    expect_run(2'd0, 1, 0, 0, 0, 4'b0010, 1);
    expect_run(2'd0, 1, 1, 0, 0, 4'b0010, 4);
    expect_run(2'd1, 1, 0, 1, 1, 4'b0000, 1);
    expect_run(2'd1, 1, 0, 1, 0, 4'b0000, 2);
    expect_run(2'd1, 1, 0, 0, 0, 4'b0000, 0);
    pulse_req(4'b0001);
    repeat (6) @(posedge clk);
    #7 rst = 1'b0;
    #1;
    check_now("async_reset", tup(2'd0, 1, 0, 0, 0, 4'b0000));
    req = 4'b1111;
    @(posedge clk);
    #1;
    check_now("reset_hold", tup(2'd0, 1, 0, 0, 0, 4'b0000));
    @(posedge clk);
    #3;
    rst = 1'b1;
    req = 4'b0010;
    @(posedge clk);
    #1 req = 4'b0000;
    drain();

    done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (flushed) break;
      @(posedge clk);
    end
    n_cmp++;
    if (!flushed || sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got %0d runs left (flushed=%0d), required 0", sb.size(), flushed);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
